bmult_share_arb: RTL
====================

Name: bmult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined WxW multiplier (e.g. Bmult6x6, clocked, fixed latency) between N_REQ requesters.
- Accepts operand pairs over valid/ready, issues at most one per cycle into the multiplier through registered operand outputs, and tracks in-flight operations with a tag pipeline.
- Returns each registered product tagged with the requester id.
- Sits between crypto-arithmetic clients and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- W, 6, operand width; product width is 2W.
- LAT, 1, multiplier latency in clock edges from operand change to valid mul_p (>=1).
- IDW, $clog2(N_REQ), requester id width (derived).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a  in  N_REQ*W  packed operand A, requester i at bits [i*W +: W].
- req_b  in  N_REQ*W  packed operand B, same packing.
- mul_a  out  W  registered operand A to multiplier.
- mul_b  out  W  registered operand B to multiplier.
- mul_p  in  2W  multiplier product.
- rsp_valid  out  1  registered response valid, one-cycle pulse per result.
- rsp_id  out  IDW  requester id of the response.
- rsp_p  out  2W  registered product.
- busy  out  1  high while any operation is in flight (tag pipe or response stage).

Behaviour:
- Reset (async, rst=1): rr pointer=0, mul_a=mul_b=0, tag pipe cleared, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0. req_ready is combinational, so it is all-zero while rst=1.
- Arbitration (combinational):
  - Among req_valid bits, grant the first set bit searching upward from pointer, wrapping modulo N_REQ.
  - req_ready is that one-hot grant; all zero if no req_valid.
  - No requirement on req_valid→req_ready ordering beyond this combinational path.
- Handshake: transfer occurs when req_valid[i]&req_ready[i] at a rising edge. A requester holds valid and operands stable until transfer. Dropping valid before transfer is legal; the request is simply not issued.
- Pointer update: on a transfer from requester g, pointer <= (g+1) mod N_REQ. With no transfer, the pointer holds.
- Issue: on a transfer, mul_a/mul_b <= the granted requester's operands and tag stage 0 <= {1, g}. With no transfer, mul_a/mul_b hold their previous value and tag stage 0 <= invalid.
- Tag pipe: LAT stages, shifting every cycle; there is no stall. Stage LAT-1 aligns with valid mul_p.
- Response:
  - rsp_valid <= tag[LAT-1].valid.
  - When that tag is valid: rsp_id <= tag id and rsp_p <= mul_p.
  - Otherwise rsp_id and rsp_p hold.
- Latency: a transfer at edge E gives rsp_valid high for exactly one cycle after edge E+LAT+1, i.e. a request accepted in cycle t responds in cycle t+LAT+2.
- Throughput: one issue per cycle; results return in issue order.
- No response backpressure; consumers must accept rsp every cycle.
- busy = OR of all tag valids OR rsp_valid.
- Arithmetic: the block never modifies products; rsp_p equals mul_p bit-for-bit (2W bits).
- Simultaneous events: all requesters valid → grants rotate 0,1,2,…,N_REQ-1,0…, one per cycle, no starvation. Maximum wait is N_REQ-1 cycles behind others.
- Reset mid-operation: all in-flight tags are discarded and no response is emitted for them. The pointer returns to 0 and arbitration resumes on the first cycle after rst deasserts.
- Invariants:
  - popcount(req_ready) <= 1.
  - req_ready[i] implies req_valid[i].

Test Plan:
- Single op (W=6, LAT=1): req_valid=0001, a=63, b=63 accepted cycle 0 → rsp_valid in cycle 3 only, rsp_id=0, rsp_p=3969; busy high cycles 1–3.
- All four valid continuously (a=i+1, b=2): grants 0,1,2,3,0 on cycles 0–4; rsp ids 0,1,2,3 on cycles 3–6 with products 2,4,6,8; no idle cycle.
- Fairness: req0 and req2 held valid for 8 cycles → grant order 0,2,0,2,…; req1/req3 never granted; counts equal (4 each).
- Late joiner: req3 valid alone for 2 transfers (pointer→0), then req1 joins while req3 stays valid → next grant is 1, then 3; pointer wrap verified.
- Reset mid-flight: issue 2 ops, assert rst one cycle after second transfer → no rsp_valid pulses, all outputs zero during reset, first post-reset request from req2 with a=0, b=45 → rsp_p=0, rsp_id=2.
- LAT=3 build: back-to-back ops from req1 (5×7) then req0 (12×12) → rsp cycles 5 and 6, products 35 and 144, ids 1 and 0.

Source files
------------

// File: rtl/bmult_share_arb.sv
// Round-robin share of one pipelined WxW multiplier among N_REQ valid/ready clients; tagged products
// return LAT+2 cycles after acceptance, in issue order, with no response backpressure (one grant per cycle).
module bmult_share_arb #(
  parameter int N_REQ = 4,
  parameter int W     = 6,
  parameter int LAT   = 1,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_p,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*W-1:0]       rsp_p,
  output logic                 busy
);

  logic [W-1:0]     a_arr [N_REQ];
  logic [W-1:0]     b_arr [N_REQ];

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand;
  logic             gnt_found;
  int               arb_idx;

  logic [W-1:0]     mul_a_q, mul_b_q;
  logic             iss_vld_q;
  logic [IDW-1:0]   iss_id_q;
  logic [LAT-1:0]   tag_vld_q;
  logic [IDW-1:0]   tag_id_q [LAT];
  logic             rsp_vld_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [2*W-1:0]   rsp_p_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    arb_idx   = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
      cand = IDW'(arb_idx);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  assign ptr_d     = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
  assign req_ready = (gnt_found && !rst) ? (N_REQ'(1) << gnt_id) : '0;

  // The issue register sits ahead of the LAT-deep tag pipe, so the last tag
  // stage lines up with the cycle in which mul_p carries that product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_p_q   <= '0;
    end else begin
      if (gnt_found) begin
        ptr_q   <= ptr_d;
        mul_a_q <= a_arr[gnt_id];
        mul_b_q <= b_arr[gnt_id];
      end
      iss_vld_q    <= gnt_found;
      iss_id_q     <= gnt_id;
      tag_vld_q[0] <= iss_vld_q;
      tag_id_q[0]  <= iss_id_q;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      rsp_vld_q <= tag_vld_q[LAT-1];
      if (tag_vld_q[LAT-1]) begin
        rsp_id_q <= tag_id_q[LAT-1];
        rsp_p_q  <= mul_p;
      end
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = iss_vld_q | (|tag_vld_q) | rsp_vld_q;

endmodule
